ps2_device_tx: RTL and testbench

- PS/2 device-side (keyboard-end) transmitter. It serialises one scan-code byte per handshake onto the open-drain PS/2 clock and data lines, generating the clock itself, so the PS2FSM host receiver can be driven and tested on-board without a physical keyboard.
- It honours host inhibit: if the host holds clock low, the frame is aborted and retried.
- It sits beside the NES driver/controller pair in the top level and is clocked from CLK_50M.

---
 rtl/ps2_device_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_device_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: serialises one byte per handshake as an 11-bit
// frame, generating the PS/2 clock itself and backing off on host inhibit.
module ps2_device_tx #(
  parameter int unsigned HALF_CYC    = 2500,
  parameter int unsigned IDLE_CYC    = 2500,
  parameter int unsigned SYNC_MARGIN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drv_low,
  output logic       ps2_data_drv_low,
  output logic       busy,
  output logic       aborted
);

  localparam int unsigned CNT_MAX = (IDLE_CYC > 2 * HALF_CYC) ? IDLE_CYC : 2 * HALF_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] MARGIN    = CW'(SYNC_MARGIN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BIT_HI,
    S_BIT_LO,
    S_HOLDOFF
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     byte_q, byte_d;
  logic           clk_s1_q, clk_s_q;
  logic           dat_s1_q, dat_s_q;
  logic [10:0]    frame;
  logic           frame_bit;

  // Released lines read high, so the synchronisers come out of reset at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s_q  <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s_q  <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s_q  <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s_q  <= dat_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
    end
  end

  assign tx_ready  = (state_q == S_IDLE) && en;
  assign busy      = (state_q != S_IDLE);
  assign frame     = {1'b1, ~^byte_q, byte_q, 1'b0};
  assign frame_bit = frame[idx_q];

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    byte_d           = byte_q;
    ps2_clk_drv_low  = 1'b0;
    ps2_data_drv_low = 1'b0;
    aborted          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          byte_d  = tx_data;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end

      // Wait for both lines to stay high; a host request-to-send just stalls here.
      S_CHECK: begin
        if (clk_s_q && dat_s_q) begin
          if (cnt_q == IDLE_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_BIT_HI;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      S_BIT_HI: begin
        ps2_data_drv_low = ~frame_bit;
        // Early cycles see our own low phase through the synchroniser, hence the mask.
        if ((cnt_q >= MARGIN) && !clk_s_q && (idx_q <= 4'd9)) begin
          ps2_data_drv_low = 1'b0;
          aborted          = 1'b1;
          cnt_d            = '0;
          state_d          = S_CHECK;
        end else if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = S_BIT_LO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_BIT_LO: begin
        ps2_clk_drv_low  = 1'b1;
        ps2_data_drv_low = ~frame_bit;
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd10) begin
            state_d = S_HOLDOFF;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_BIT_HI;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: directed bytes with hand-computed frames,
// checked by a host-side receiver model on the open-drain lines.
module tb_ps2_device_tx;

  localparam int unsigned HALF = 4;
  localparam int unsigned IDLE = 8;
  localparam int unsigned MARG = 2;
  localparam int unsigned TMO  = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, aborted;
  logic       ps2_clk_drv_low, ps2_data_drv_low;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_drv_low | host_clk_low);
  assign ps2_data_in = ~(ps2_data_drv_low | host_data_low);

  always #5 clk = ~clk;

  ps2_device_tx #(.HALF_CYC(HALF), .IDLE_CYC(IDLE), .SYNC_MARGIN(MARG)) dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .ps2_clk_in       (ps2_clk_in),
    .ps2_data_in      (ps2_data_in),
    .ps2_clk_drv_low  (ps2_clk_drv_low),
    .ps2_data_drv_low (ps2_data_drv_low),
    .busy             (busy),
    .aborted          (aborted)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [10:0] exp_q[$];

  // Host receiver model state (monitor-owned)
  int unsigned cyc = 0;
  int unsigned frames_done = 0;
  int unsigned abort_cnt = 0;
  int unsigned good = 0;
  logic [3:0]  host_n = 4'd0;
  logic [10:0] rx = '0;
  int unsigned ecyc[11];
  logic        line_prev = 1'b1;
  logic        hc_prev = 1'b0;

  // Stimulus-owned negedge counter
  int unsigned sc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Host samples data on every falling clock edge it did not cause itself.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      host_n    = 4'd0;
      line_prev = 1'b1;
    end else begin
      if (aborted) abort_cnt++;
      if (host_clk_low && !hc_prev && (host_n < 4'd10)) host_n = 4'd0;
      if (line_prev && !ps2_clk_in && !host_clk_low) begin
        rx[host_n]   = ps2_data_in;
        ecyc[host_n] = cyc;
        if (host_n == 4'd10) begin
          good = 0;
          for (int i = 1; i < 11; i++) if (ecyc[i] - ecyc[i-1] == 2 * HALF) good++;
          check("edge_spacing", 32'(good), 32'd10);
          check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("frame_bits", 32'(rx), 32'(exp_q.pop_front()));
          host_n = 4'd0;
          frames_done++;
        end else begin
          host_n++;
        end
      end
      line_prev = ps2_clk_in;
    end
    hc_prev = host_clk_low;
  end

  task automatic tick();
    @(negedge clk);
    sc++;
  endtask

  task automatic offer(input logic [7:0] d, input logic [10:0] f, output int unsigned acc);
    int unsigned n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < TMO) begin tick(); n++; end
    check("accept_in_time", 32'(n < TMO), 32'd1);
    exp_q.push_back(f);
    acc = sc;
    tick();
  endtask

  task automatic start_lat(input string name, input int unsigned exp);
    int unsigned n = 0;
    while (!ps2_data_drv_low && n < 100) begin tick(); n++; end
    check(name, 32'(n), 32'(exp));
  endtask

  task automatic tail(input string name, input int unsigned target, input logic use_ready);
    int unsigned n = 0;
    int unsigned m = 0;
    while (frames_done < target && n < TMO) begin tick(); n++; end
    check({name, "_frame_done"}, 32'(n < TMO), 32'd1);
    while (ps2_clk_drv_low && n < TMO) begin tick(); n++; end
    while (!(use_ready ? tx_ready : !busy) && m < 100) begin tick(); m++; end
    check(name, 32'(m), 32'(2 * HALF));
  endtask

  initial begin
    int unsigned acc1, acc2, a0, f0, n;

    // Reset state
    repeat (3) tick();
    check("rst_clk_drv", 32'(ps2_clk_drv_low), 32'd0);
    check("rst_data_drv", 32'(ps2_data_drv_low), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_ready_en1", 32'(tx_ready), 32'd1);
    en = 1'b0;
    tick();
    check("rst_ready_en0", 32'(tx_ready), 32'd0);
    en = 1'b1;
    reset = 1'b1;
    repeat (3) tick();

    // 0x1C on idle lines: start latency, frame, holdoff
    f0 = frames_done;
    offer(8'h1C, 11'h438, acc1);
    tx_valid = 1'b0;
    start_lat("start_latency_idle", IDLE);
    tail("holdoff_to_ready", f0 + 1, 1'b1);
    repeat (4) tick();
    check("no_extra_edges", 32'(host_n), 32'd0);

    // Reset during bit 5's low phase
    offer(8'h00, 11'h600, acc1);
    tx_valid = 1'b0;
    n = 0;
    while (!(host_n == 4'd6 && !ps2_clk_in) && n < TMO) begin tick(); n++; end
    check("reach_bit5", 32'(n < TMO), 32'd1);
    check("bit5_lines_driven", 32'({ps2_clk_drv_low, ps2_data_drv_low}), 32'd3);
    reset = 1'b0;
    #1;
    check("midrst_clk_drv", 32'(ps2_clk_drv_low), 32'd0);
    check("midrst_data_drv", 32'(ps2_data_drv_low), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(tx_ready), 32'd1);
    repeat (2) tick();

    // Back-to-back 0x00, 0xFF with tx_valid held: 8 check + 88 frame + 8 holdoff + 1
    f0 = frames_done;
    offer(8'h00, 11'h600, acc1);
    offer(8'hFF, 11'h7FE, acc2);
    tx_valid = 1'b0;
    check("b2b_accept_spacing", 32'(acc2 - acc1), 32'd105);
    tail("b2b_holdoff_to_idle", f0 + 2, 1'b0);

    // Host inhibit during bit 3 high phase
    f0 = frames_done;
    a0 = abort_cnt;
    offer(8'h1C, 11'h438, acc1);
    tx_valid = 1'b0;
    n = 0;
    while (!(host_n == 4'd3 && ps2_clk_in) && n < TMO) begin tick(); n++; end
    check("reach_bit3", 32'(n < TMO), 32'd1);
    tick();
    host_clk_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (aborted) check("abort_lines_released", 32'({ps2_clk_drv_low, ps2_data_drv_low}), 32'd0);
    end
    host_clk_low = 1'b0;
    // two synchroniser cycles plus the idle window
    start_lat("restart_latency", IDLE + 2);
    tail("abort_frame_tail", f0 + 1, 1'b1);
    check("abort_pulses", 32'(abort_cnt - a0), 32'd1);

    // Host inhibit during the stop-bit high phase is ignored
    f0 = frames_done;
    a0 = abort_cnt;
    offer(8'h5A, 11'h6B4, acc1);
    tx_valid = 1'b0;
    n = 0;
    while (!(host_n == 4'd10 && ps2_clk_in) && n < TMO) begin tick(); n++; end
    check("reach_stop", 32'(n < TMO), 32'd1);
    host_clk_low = 1'b1;
    tick();
    tick();
    host_clk_low = 1'b0;
    tail("stop_inhibit_busy", f0 + 1, 1'b0);
    check("stop_inhibit_no_abort", 32'(abort_cnt - a0), 32'd0);

    // Data held low by host while a byte is pending
    f0 = frames_done;
    host_data_low = 1'b1;
    tick();
    offer(8'hA5, 11'h74A, acc1);
    tx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ps2_clk_drv_low || ps2_data_drv_low) n++;
    end
    check("rts_no_clock", 32'(n), 32'd0);
    check("rts_busy", 32'(busy), 32'd1);
    host_data_low = 1'b0;
    start_lat("rts_release_latency", IDLE + 2);
    tail("rts_tail", f0 + 1, 1'b1);

    // en low blocks acceptance
    en       = 1'b0;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_ready || busy) n++;
    end
    check("en0_no_accept", 32'(n), 32'd0);
    tx_valid = 1'b0;
    en       = 1'b1;

    n = 0;
    while (exp_q.size() > 0 && n < TMO) begin tick(); n++; end
    repeat (20) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("host_idle", 32'(host_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
